// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register: holds execute results, the in-flight instruction and
// memory/writeback control for one cycle, with hazard-unit stall and flush.
module ex_mem_stage_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        stall,
    input  logic        flush,
    input  logic [7:0]  data_top_in,
    input  logic [7:0]  data_bot_in,
    input  logic [31:0] instruction_in,
    input  logic        mem_wen_in,
    input  logic        main_memory_enable_in,
    input  logic        frame_buffer_enable_in,
    input  logic        call_stack_enable_in,
    input  logic        prog_mem_enable_in,
    input  logic [6:0]  mem_ptr_ctl_in,
    input  logic [3:0]  mem_wb_data_sel_top_in,
    input  logic [6:0]  mem_wb_data_sel_bot_in,
    input  logic [4:0]  sfr_file_input_sel_in,
    input  logic [3:0]  mem_str_data_sel_top_in,
    input  logic [3:0]  mem_str_data_sel_bot_in,
    input  logic [1:0]  reg_file_wen_in,
    input  logic [1:0]  sfr_file_wren_in,
    input  logic [13:0] call_addr_in,
    output logic [7:0]  data_top_out,
    output logic [7:0]  data_bot_out,
    output logic [31:0] instruction_out,
    output logic        mem_wen_out,
    output logic        main_memory_enable_out,
    output logic        frame_buffer_enable_out,
    output logic        call_stack_enable_out,
    output logic        prog_mem_enable_out,
    output logic [6:0]  mem_ptr_ctl_out,
    output logic [3:0]  mem_wb_data_sel_top_out,
    output logic [6:0]  mem_wb_data_sel_bot_out,
    output logic [4:0]  sfr_file_input_sel_out,
    output logic [3:0]  mem_str_data_sel_top_out,
    output logic [3:0]  mem_str_data_sel_bot_out,
    output logic [1:0]  reg_file_wen_out,
    output logic [1:0]  sfr_file_wren_out,
    output logic [13:0] call_addr_out
);

    // Everything except the instruction word clears to zero on reset and bubble,
    // so those fields are carried together as one packed bus.
    localparam int CW = 70;

    logic [CW-1:0] ctrl_in;
    logic [CW-1:0] ctrl_d;
    logic [CW-1:0] ctrl_q;
    logic [31:0]   instr_d;
    logic [31:0]   instr_q;

    assign ctrl_in = {data_top_in, data_bot_in,
                      mem_wen_in, main_memory_enable_in, frame_buffer_enable_in,
                      call_stack_enable_in, prog_mem_enable_in,
                      mem_ptr_ctl_in, mem_wb_data_sel_top_in, mem_wb_data_sel_bot_in,
                      sfr_file_input_sel_in, mem_str_data_sel_top_in, mem_str_data_sel_bot_in,
                      reg_file_wen_in, sfr_file_wren_in, call_addr_in};

    always_comb begin
        ctrl_d  = ctrl_q;
        instr_d = instr_q;
        if (flush) begin
            ctrl_d  = '0;
            instr_d = NOP_INSTR;
        end else if (!stall) begin
            ctrl_d  = ctrl_in;
            instr_d = instruction_in;
        end
    end

    always_ff @(posedge clock or posedge nreset) begin
        if (nreset) begin
            ctrl_q  <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            ctrl_q  <= ctrl_d;
            instr_q <= instr_d;
        end
    end

    assign instruction_out = instr_q;
    assign {data_top_out, data_bot_out,
            mem_wen_out, main_memory_enable_out, frame_buffer_enable_out,
            call_stack_enable_out, prog_mem_enable_out,
            mem_ptr_ctl_out, mem_wb_data_sel_top_out, mem_wb_data_sel_bot_out,
            sfr_file_input_sel_out, mem_str_data_sel_top_out, mem_str_data_sel_bot_out,
            reg_file_wen_out, sfr_file_wren_out, call_addr_out} = ctrl_q;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Scoreboard bench for the EX/MEM register: stimulus pushes expected outputs,
// a monitor pops and compares them after each edge (or on an async-reset probe).
module tb_ex_mem_stage_reg;

    typedef struct packed {
        logic [7:0]  dt;
        logic [7:0]  db;
        logic [31:0] instr;
        logic        wen;
        logic        mme;
        logic        fbe;
        logic        cse;
        logic        pme;
        logic [6:0]  ptr;
        logic [3:0]  wbt;
        logic [6:0]  wbb;
        logic [4:0]  sfrsel;
        logic [3:0]  sdt;
        logic [3:0]  sdb;
        logic [1:0]  rfw;
        logic [1:0]  sfw;
        logic [13:0] call;
    } fields_t;

    typedef struct {
        string   name;
        fields_t exp;
    } sb_entry_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clock = 1'b0;
    logic nreset = 1'b1;
    logic stall = 1'b0;
    logic flush = 1'b0;
    fields_t in_v = '0;
    fields_t out_v;

    logic [7:0]  data_top_in, data_bot_in, data_top_out, data_bot_out;
    logic [31:0] instruction_in, instruction_out;
    logic        mem_wen_in, main_memory_enable_in, frame_buffer_enable_in;
    logic        call_stack_enable_in, prog_mem_enable_in;
    logic        mem_wen_out, main_memory_enable_out, frame_buffer_enable_out;
    logic        call_stack_enable_out, prog_mem_enable_out;
    logic [6:0]  mem_ptr_ctl_in, mem_ptr_ctl_out, mem_wb_data_sel_bot_in, mem_wb_data_sel_bot_out;
    logic [3:0]  mem_wb_data_sel_top_in, mem_wb_data_sel_top_out;
    logic [4:0]  sfr_file_input_sel_in, sfr_file_input_sel_out;
    logic [3:0]  mem_str_data_sel_top_in, mem_str_data_sel_top_out;
    logic [3:0]  mem_str_data_sel_bot_in, mem_str_data_sel_bot_out;
    logic [1:0]  reg_file_wen_in, reg_file_wen_out, sfr_file_wren_in, sfr_file_wren_out;
    logic [13:0] call_addr_in, call_addr_out;

    assign {data_top_in, data_bot_in, instruction_in,
            mem_wen_in, main_memory_enable_in, frame_buffer_enable_in,
            call_stack_enable_in, prog_mem_enable_in,
            mem_ptr_ctl_in, mem_wb_data_sel_top_in, mem_wb_data_sel_bot_in,
            sfr_file_input_sel_in, mem_str_data_sel_top_in, mem_str_data_sel_bot_in,
            reg_file_wen_in, sfr_file_wren_in, call_addr_in} = in_v;

    assign out_v = {data_top_out, data_bot_out, instruction_out,
                    mem_wen_out, main_memory_enable_out, frame_buffer_enable_out,
                    call_stack_enable_out, prog_mem_enable_out,
                    mem_ptr_ctl_out, mem_wb_data_sel_top_out, mem_wb_data_sel_bot_out,
                    sfr_file_input_sel_out, mem_str_data_sel_top_out, mem_str_data_sel_bot_out,
                    reg_file_wen_out, sfr_file_wren_out, call_addr_out};

    ex_mem_stage_reg #(.NOP_INSTR(NOP)) dut (
        .clock(clock), .nreset(nreset), .stall(stall), .flush(flush),
        .data_top_in(data_top_in), .data_bot_in(data_bot_in),
        .instruction_in(instruction_in),
        .mem_wen_in(mem_wen_in), .main_memory_enable_in(main_memory_enable_in),
        .frame_buffer_enable_in(frame_buffer_enable_in),
        .call_stack_enable_in(call_stack_enable_in), .prog_mem_enable_in(prog_mem_enable_in),
        .mem_ptr_ctl_in(mem_ptr_ctl_in),
        .mem_wb_data_sel_top_in(mem_wb_data_sel_top_in), .mem_wb_data_sel_bot_in(mem_wb_data_sel_bot_in),
        .sfr_file_input_sel_in(sfr_file_input_sel_in),
        .mem_str_data_sel_top_in(mem_str_data_sel_top_in), .mem_str_data_sel_bot_in(mem_str_data_sel_bot_in),
        .reg_file_wen_in(reg_file_wen_in), .sfr_file_wren_in(sfr_file_wren_in),
        .call_addr_in(call_addr_in),
        .data_top_out(data_top_out), .data_bot_out(data_bot_out),
        .instruction_out(instruction_out),
        .mem_wen_out(mem_wen_out), .main_memory_enable_out(main_memory_enable_out),
        .frame_buffer_enable_out(frame_buffer_enable_out),
        .call_stack_enable_out(call_stack_enable_out), .prog_mem_enable_out(prog_mem_enable_out),
        .mem_ptr_ctl_out(mem_ptr_ctl_out),
        .mem_wb_data_sel_top_out(mem_wb_data_sel_top_out), .mem_wb_data_sel_bot_out(mem_wb_data_sel_bot_out),
        .sfr_file_input_sel_out(sfr_file_input_sel_out),
        .mem_str_data_sel_top_out(mem_str_data_sel_top_out), .mem_str_data_sel_bot_out(mem_str_data_sel_bot_out),
        .reg_file_wen_out(reg_file_wen_out), .sfr_file_wren_out(sfr_file_wren_out),
        .call_addr_out(call_addr_out)
    );

    always #5 clock = ~clock;

    sb_entry_t sb[$];
    event      probe_ev;
    logic      done = 1'b0;
    int        errors = 0;
    int        checks = 0;

    // Push the hand-computed expectation for the edge that follows.
    task automatic apply(input fields_t v, input logic st, input logic fl,
                         input fields_t exp, input string nm);
        @(negedge clock);
        in_v  = v;
        stall = st;
        flush = fl;
        @(posedge clock);
        #1;
        sb.push_back('{nm, exp});
    endtask

    function automatic fields_t rand_fields();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return fields_t'(r[101:0]);
    endfunction

    fields_t bubble;
    fields_t v, v2, ones, alt_a, alt_b;
    logic [31:0] stream [8];

    initial begin
        bubble       = '0;
        bubble.instr = NOP;

        // 1. reset holds outputs cleared while inputs toggle
        apply(rand_fields(), 1'b0, 1'b0, bubble, "reset_hold_0");
        apply(rand_fields(), 1'b1, 1'b0, bubble, "reset_hold_1");
        @(negedge clock);
        nreset = 1'b0;
        v = '0; v.dt = 8'hA5; v.db = 8'h3C; v.instr = 32'h0001_2300;
        apply(v, 1'b0, 1'b0, v, "first_load");

        // 2. all-ones and alternating patterns
        ones = '1;
        apply(ones, 1'b0, 1'b0, ones, "all_ones");
        alt_a = {51{2'b10}};
        alt_b = {51{2'b01}};
        apply(alt_a, 1'b0, 1'b0, alt_a, "alt_10");
        apply(alt_b, 1'b0, 1'b0, alt_b, "alt_01");
        v = '0; v.dt = 8'h81; v.db = 8'h7E; v.instr = 32'h0003_FF00; v.pme = 1'b1;
        v.ptr = 7'h41; v.wbt = 4'h9; v.wbb = 7'h22; v.sfrsel = 5'h11; v.sdt = 4'h6;
        v.sdb = 4'hC; v.rfw = 2'b10; v.sfw = 2'b01; v.call = 14'h2001;
        apply(v, 1'b0, 1'b0, v, "field_mix");

        // 3. stall holds, release loads the new value
        v = '0; v.call = 14'h1234; v.wen = 1'b1;
        apply(v, 1'b0, 1'b0, v, "stall_pre");
        v2 = '0; v2.call = 14'h0ABC;
        for (int i = 0; i < 3; i++) apply(v2, 1'b1, 1'b0, v, "stall_hold");
        apply(v2, 1'b0, 1'b0, v2, "stall_release");

        // 4. flush beats stall
        v = '0; v.rfw = 2'b11; v.sfw = 2'b01; v.mme = 1'b1; v.instr = 32'hDEAD_BEEF;
        v.ptr = 7'h15; v.wen = 1'b1; v.dt = 8'h12;
        apply(v, 1'b0, 1'b0, v, "flush_pre");
        apply(ones, 1'b1, 1'b1, bubble, "flush_over_stall");
        apply(ones, 1'b0, 1'b1, bubble, "flush_plain");

        // 5. asynchronous reset between edges
        v = '0; v.dt = 8'hFF; v.instr = 32'hCAFE_0100; v.wen = 1'b1; v.call = 14'h3001;
        apply(v, 1'b0, 1'b0, v, "async_pre");
        @(negedge clock);
        #2;
        nreset = 1'b1;
        #1;
        sb.push_back('{"async_reset", bubble});
        ->probe_ev;
        @(negedge clock);
        nreset = 1'b0;

        // 6. back-to-back stream, one instruction per cycle
        stream = '{32'h0000_0101, 32'h1111_0202, 32'h2222_0303, 32'h3333_0404,
                   32'h4444_0505, 32'h5555_0606, 32'h6666_0707, 32'h7777_0808};
        for (int i = 0; i < 8; i++) begin
            v = '0; v.instr = stream[i]; v.db = 8'(i + 1);
            apply(v, 1'b0, 1'b0, v, "stream");
        end
        done = 1'b1;
    end

    initial begin : monitor
        sb_entry_t e;
        int cycles;
        cycles = 0;
        forever begin
            @(negedge clock or probe_ev);
            cycles++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (out_v !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, out_v, e.exp);
                end else begin
                    $display("check %0d %s ok %h", checks, e.name, out_v);
                end
            end
            if (done && sb.size() == 0) break;
            if (cycles > 2000) begin
                errors++;
                $display("FAIL timeout: pending=%0d expected 0", sb.size());
                break;
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
